// File: rtl/lmsm_sequencer_if.sv
// Instruction/stall bundle between IF_ID, the LM/SM sequencer and ID_RR.
// The master side is the pipeline control (IF_ID feed, hazard inputs); the slave side is the sequencer.
interface lmsm_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_ir;
  logic [WIDTH-1:0] in_npc;
  logic             hold_in;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_ir;
  logic [WIDTH-1:0] out_npc;
  logic             stall_up;
  logic             busy;

  modport master (
    output in_valid, in_ir, in_npc, hold_in, flush,
    input  out_valid, out_ir, out_npc, stall_up, busy
  );

  modport slave (
    input  in_valid, in_ir, in_npc, hold_in, flush,
    output out_valid, out_ir, out_npc, stall_up, busy
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into one LW/SW micro-op per listed register at the ID->RR boundary,
// stalling IF/ID while an expansion is in progress; other instructions pass through.
//
//   state  | meaning
//   IDLE   | accept IF_ID; pass through, bubble, or emit first micro-op of LM/SM
//   EXPAND | emitting remaining micro-ops from list_q; IF/ID held on the LM/SM
module lmsm_sequencer #(
  parameter int         WIDTH = 16,
  parameter logic [3:0] OP_LM = 4'b0110,
  parameter logic [3:0] OP_SM = 4'b0111,
  parameter logic [3:0] OP_LW = 4'b0100,
  parameter logic [3:0] OP_SW = 4'b0101
) (
  input  logic             clk,
  input  logic             reset,
  lmsm_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t           state_q, state_d;
  logic [7:0]       list_q, list_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       ra_q, ra_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_ir_q, out_ir_d;
  logic [WIDTH-1:0] out_npc_q, out_npc_d;

  logic [3:0]  in_op;
  logic        in_is_multi;
  logic [7:0]  src_list;
  logic [2:0]  hi_idx;
  logic [2:0]  rd;
  logic [7:0]  list_rest;
  logic        more_left;
  logic [3:0]  emit_op;
  logic [2:0]  emit_ra;
  logic [2:0]  emit_off;
  logic [15:0] uop;
  logic        stall_comb;

  assign in_op       = bus.in_ir[15:12];
  assign in_is_multi = (in_op == OP_LM) || (in_op == OP_SM);
  assign src_list    = (state_q == EXPAND) ? list_q : bus.in_ir[7:0];

  // List bit 7 names R0, so the highest set bit is the next register in R0-first order.
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (src_list[i]) hi_idx = 3'(i);
    end
  end

  assign rd        = 3'd7 - hi_idx;
  assign list_rest = src_list & ~(8'd1 << hi_idx);
  assign more_left = |list_rest;

  assign emit_op  = (state_q == EXPAND) ? op_q : ((in_op == OP_LM) ? OP_LW : OP_SW);
  assign emit_ra  = (state_q == EXPAND) ? ra_q : bus.in_ir[11:9];
  assign emit_off = (state_q == EXPAND) ? cnt_q : 3'd0;
  assign uop      = {emit_op, rd, emit_ra, 3'b000, emit_off};

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ra_d        = ra_q;
    npc_d       = npc_q;
    out_valid_d = out_valid_q;
    out_ir_d    = out_ir_q;
    out_npc_d   = out_npc_q;
    stall_comb  = 1'b0;

    if (bus.flush) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
      list_d      = 8'd0;
      cnt_d       = 3'd0;
    end else if (bus.hold_in) begin
      stall_comb = 1'b1;
    end else if (state_q == EXPAND) begin
      out_valid_d = 1'b1;
      out_ir_d    = WIDTH'(uop);
      out_npc_d   = npc_q;
      if (more_left) begin
        list_d     = list_rest;
        cnt_d      = cnt_q + 3'd1;
        stall_comb = 1'b1;
      end else begin
        list_d  = 8'd0;
        cnt_d   = 3'd0;
        state_d = IDLE;
      end
    end else if (!bus.in_valid) begin
      out_valid_d = 1'b0;
    end else if (!in_is_multi) begin
      out_valid_d = 1'b1;
      out_ir_d    = bus.in_ir;
      out_npc_d   = bus.in_npc;
    end else if (src_list == 8'd0) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = 1'b1;
      out_ir_d    = WIDTH'(uop);
      out_npc_d   = bus.in_npc;
      if (more_left) begin
        state_d    = EXPAND;
        list_d     = list_rest;
        cnt_d      = 3'd1;
        op_d       = emit_op;
        ra_d       = emit_ra;
        npc_d      = bus.in_npc;
        stall_comb = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      list_q      <= 8'd0;
      cnt_q       <= 3'd0;
      op_q        <= 4'd0;
      ra_q        <= 3'd0;
      npc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ir_q    <= '0;
      out_npc_q   <= '0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      npc_q       <= npc_d;
      out_valid_q <= out_valid_d;
      out_ir_q    <= out_ir_d;
      out_npc_q   <= out_npc_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ir    = out_ir_q;
  assign bus.out_npc   = out_npc_q;
  assign bus.stall_up  = stall_comb && !reset;
  assign bus.busy      = (state_q == EXPAND);

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed and randomized bench for lmsm_sequencer against a queue-based model of LM/SM expansion.
module tb_lmsm_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lmsm_sequencer_if #(.WIDTH(16)) bus ();

  lmsm_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: pending registers of the current expansion, in emission order.
  int          pend_q[$];
  int          m_cnt;
  logic [3:0]  m_op;
  logic [2:0]  m_ra;
  logic [15:0] m_hnpc;
  logic        m_valid;
  logic [15:0] m_ir;
  logic [15:0] m_npc;

  logic        cur_v, cur_h, cur_f, cur_r;
  logic [15:0] cur_ir, cur_npc;
  logic        exp_stall;
  logic        dut_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_multi(input logic [15:0] ir);
    return (ir[15:12] == 4'b0110) || (ir[15:12] == 4'b0111);
  endfunction

  function automatic logic model_stall();
    if (cur_r || cur_f) return 1'b0;
    if (cur_h) return 1'b1;
    if (pend_q.size() > 0) return pend_q.size() > 1;
    if (cur_v && is_multi(cur_ir)) return $countones(cur_ir[7:0]) >= 2;
    return 1'b0;
  endfunction

  task automatic model_emit();
    int r;
    r       = pend_q.pop_front();
    m_ir    = {m_op, 3'(r), m_ra, 3'b000, 3'(m_cnt)};
    m_npc   = m_hnpc;
    m_valid = 1'b1;
    m_cnt++;
  endtask

  task automatic model_edge();
    if (cur_r) begin
      m_valid = 1'b0; m_ir = '0; m_npc = '0; pend_q.delete(); m_cnt = 0;
    end else if (cur_f) begin
      m_valid = 1'b0; pend_q.delete(); m_cnt = 0;
    end else if (cur_h) begin
      // frozen
    end else if (pend_q.size() > 0) begin
      model_emit();
    end else if (!cur_v) begin
      m_valid = 1'b0;
    end else if (!is_multi(cur_ir)) begin
      m_valid = 1'b1; m_ir = cur_ir; m_npc = cur_npc;
    end else begin
      m_op   = (cur_ir[15:12] == 4'b0110) ? 4'b0100 : 4'b0101;
      m_ra   = cur_ir[11:9];
      m_hnpc = cur_npc;
      m_cnt  = 0;
      for (int r = 0; r < 8; r++) if (cur_ir[7-r]) pend_q.push_back(r);
      if (pend_q.size() == 0) m_valid = 1'b0;
      else model_emit();
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ir, input logic [15:0] npc,
                      input logic h, input logic f, input logic r);
    @(negedge clk);
    cur_v = v; cur_ir = ir; cur_npc = npc; cur_h = h; cur_f = f; cur_r = r;
    bus.in_valid = v; bus.in_ir = ir; bus.in_npc = npc;
    bus.hold_in = h; bus.flush = f; reset = r;
    #1;
    exp_stall = model_stall();
    dut_stall = bus.stall_up;
    chk("stall_up", bus.stall_up, exp_stall);
    if (!r) chk("busy_pre", bus.busy, pend_q.size() > 0);
    model_edge();
    @(posedge clk);
    #1;
    chk("out_valid", bus.out_valid, m_valid);
    chk("busy", bus.busy, pend_q.size() > 0);
    if (m_valid || r) begin
      chk("out_ir", bus.out_ir, m_ir);
      chk("out_npc", bus.out_npc, m_npc);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ir;
    int kind;
    ir   = 16'($urandom);
    kind = int'($urandom_range(0, 5));
    if (kind <= 1) begin
      if (is_multi(ir)) ir[15:12] = 4'b0001;
    end else begin
      ir[15:12] = (kind[0]) ? 4'b0111 : 4'b0110;
      case ($urandom_range(0, 4))
        0: ir[7:0] = 8'h00;
        1: ir[7:0] = 8'h01 << $urandom_range(0, 7);
        2: ir[7:0] = 8'hFF;
        default: ;
      endcase
    end
    return ir;
  endfunction

  initial begin
    logic [15:0] ir, npc;
    logic v, h, f, r;
    int stall_cnt;

    bus.in_valid = 1'b0; bus.in_ir = '0; bus.in_npc = '0;
    bus.hold_in = 1'b0; bus.flush = 1'b0; reset = 1'b1;
    cur_v = 1'b0; cur_ir = '0; cur_npc = '0; cur_h = 1'b0; cur_f = 1'b0; cur_r = 1'b1;
    m_valid = 1'b0; m_ir = '0; m_npc = '0; m_cnt = 0; m_op = '0; m_ra = '0; m_hnpc = '0;

    step(0, 16'h0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 16'h0, 0, 0, 1);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_ir", bus.out_ir, 16'h0000);

    step(1, 16'h1050, 16'h0004, 0, 0, 0);
    chk("add_ir", bus.out_ir, 16'h1050);
    chk("add_npc", bus.out_npc, 16'h0004);
    chk("add_stall", dut_stall, 1'b0);

    step(1, 16'h6481, 16'h0006, 0, 0, 0);
    chk("lm_uop0", bus.out_ir, 16'h4080);
    chk("lm_stall0", dut_stall, 1'b1);
    step(1, 16'h6481, 16'h0006, 0, 0, 0);
    chk("lm_uop1", bus.out_ir, 16'h4E81);
    chk("lm_stall1", dut_stall, 1'b0);
    chk("lm_npc", bus.out_npc, 16'h0006);

    stall_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 16'h72FF, 16'h0008, 0, 0, 0);
      if (dut_stall) stall_cnt++;
      chk("sm_uop", bus.out_ir, {4'b0101, 3'(k), 3'd1, 3'd0, 3'(k)});
    end
    chk("sm_stall_cycles", stall_cnt, 7);

    step(1, 16'h6000, 16'h000A, 0, 0, 0);
    chk("lm0_bubble", bus.out_valid, 1'b0);
    chk("lm0_stall", dut_stall, 1'b0);
    step(1, 16'h1234, 16'h000C, 0, 0, 0);
    chk("after_bubble", bus.out_ir, 16'h1234);

    step(1, 16'h60F0, 16'h000E, 0, 0, 0);
    chk("hold_uop0", bus.out_ir, 16'h4000);
    step(1, 16'h60F0, 16'h000E, 1, 0, 0);
    chk("hold_frozen", bus.out_ir, 16'h4000);
    chk("hold_stall", dut_stall, 1'b1);
    step(1, 16'h60F0, 16'h000E, 0, 0, 0);
    chk("hold_uop1", bus.out_ir, 16'h4201);
    step(1, 16'h60F0, 16'h000E, 0, 0, 0);
    step(1, 16'h60F0, 16'h000E, 0, 0, 0);
    chk("hold_uop3", bus.out_ir, 16'h4603);
    chk("hold_done", bus.busy, 1'b0);

    step(1, 16'h60FF, 16'h0010, 0, 0, 0);
    step(1, 16'h60FF, 16'h0010, 0, 0, 0);
    step(1, 16'h60FF, 16'h0010, 0, 1, 0);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_busy", bus.busy, 1'b0);
    step(0, 16'h60FF, 16'h0010, 0, 0, 0);
    chk("flush_stall", dut_stall, 1'b0);
    step(1, 16'h60FF, 16'h0012, 0, 0, 0);
    step(1, 16'h60FF, 16'h0012, 0, 0, 1);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_valid", bus.out_valid, 1'b0);

    v = 1'b1; ir = rand_instr(); npc = 16'h0100;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      h = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(v, ir, npc, h, f, r);
      if (!exp_stall || f || r) begin
        v   = ($urandom_range(0, 4) != 0);
        ir  = rand_instr();
        npc = npc + 16'd2;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
